// File: rtl/bfp16_div.sv
// bfp16_div: iterative bfloat16 divider, out = a / b.
// Restoring radix-2 mantissa division, one quotient bit per clock, with
// valid/ready handshakes on operand and result sides.
// Build option: define BFP16_DIV_RNE_EN for round-to-nearest-even;
// the default build truncates the quotient fraction.
module bfp16_div #(
    parameter int n_bit = 16,
    parameter int manti = 8,
    parameter int expo  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n_bit-1:0] a,
    input  logic [n_bit-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n_bit-1:0] out,
    output logic             busy
);

    localparam int FW = manti - 1;   // stored fraction bits (hidden bit excluded)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    // Division datapath registers (not reset: only meaningful after accept)
    logic        [9:0]   rem;       // partial remainder, always < 2*dvs
    logic        [7:0]   dvs;       // divisor mantissa with hidden bit
    logic        [9:0]   q;         // quotient, 1 integer + 9 fraction bits
    logic        [3:0]   cnt;       // iteration counter
    logic                sgn;       // result sign
    logic signed [9:0]   e_diff;    // ea - eb, bias added at normalization

    // Operand fields
    logic [expo-1:0] ea, eb;
    logic [FW-1:0]   fa, fb;
    logic            sgn_in;
    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic            spec_hit;
    logic [n_bit-1:0] spec_res;

    // Iteration and normalization signals
    logic signed [10:0] trial;
    logic        [9:0]  rem_keep;
    logic        [6:0]  frac_n;
    logic        [7:0]  frac_r;
    logic signed [9:0]  e_n;
    logic signed [9:0]  e_r;
    logic [n_bit-1:0]   norm_res;
`ifdef BFP16_DIV_RNE_EN
    logic               guard_n;
    logic               sticky_n;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    assign ea     = a[n_bit-2 -: expo];
    assign eb     = b[n_bit-2 -: expo];
    assign fa     = a[FW-1:0];
    assign fb     = b[FW-1:0];
    assign sgn_in = a[n_bit-1] ^ b[n_bit-1];

    assign a_nan  = (ea == 8'hFF) && (fa != 7'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 7'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 7'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 7'd0);
    assign a_zero = (ea == 8'h00);   // subnormals flush to zero
    assign b_zero = (eb == 8'h00);

`ifdef BFP16_DIV_RNE_EN
    // Round-to-nearest-even on a 7-bit fraction; bit 7 of the result is the carry-out.
    function automatic logic [7:0] round_rne(input logic [6:0] frac,
                                             input logic       guard,
                                             input logic       sticky);
        logic inc;
        inc = guard & (sticky | frac[0]);
        return {1'b0, frac} + {7'd0, inc};
    endfunction
`endif

    // Classify operands at accept; special cases bypass the divider in priority order.
    always_comb begin
        spec_hit = 1'b1;
        spec_res = 16'h7FC0;
        if (a_nan || b_nan) begin
            spec_res = 16'h7FC0;
        end else if (a_inf && b_inf) begin
            spec_res = 16'h7FC0;
        end else if (a_zero && b_zero) begin
            spec_res = 16'h7FC0;
        end else if (a_inf) begin
            spec_res = {sgn_in, 8'hFF, 7'd0};
        end else if (b_zero) begin
            spec_res = {sgn_in, 8'hFF, 7'd0};
        end else if (a_zero) begin
            spec_res = {sgn_in, 15'd0};
        end else if (b_inf) begin
            spec_res = {sgn_in, 15'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring step: subtract divisor, keep the difference only if non-negative.
    always_comb begin
        trial    = $signed({1'b0, rem}) - $signed({3'b000, dvs});
        rem_keep = trial[10] ? rem : trial[9:0];
    end

    // Normalize the finished quotient, round, and clamp the exponent range.
    always_comb begin
        if (q[9]) begin
            frac_n = q[8:2];
            e_n    = e_diff + 10'sd127;
        end else begin
            frac_n = q[7:1];
            e_n    = e_diff + 10'sd126;
        end
`ifdef BFP16_DIV_RNE_EN
        if (q[9]) begin
            guard_n  = q[1];
            sticky_n = q[0] | (rem != 10'd0);
        end else begin
            guard_n  = q[0];
            sticky_n = (rem != 10'd0);
        end
        frac_r = round_rne(frac_n, guard_n, sticky_n);
`else
        frac_r = {1'b0, frac_n};
`endif
        e_r = e_n + $signed({9'd0, frac_r[7]});
        if (e_r >= 10'sd255) begin
            norm_res = {sgn, 8'hFF, 7'd0};
        end else if (e_r <= 10'sd0) begin
            norm_res = {sgn, 15'd0};
        end else begin
            norm_res = {sgn, e_r[7:0], frac_r[6:0]};
        end
    end

    // Control FSM with registered result and valid; datapath registers load alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= 16'h0000;
            out_valid <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn <= sgn_in;
                        if (spec_hit) begin
                            out       <= spec_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem    <= {2'b01, fa};
                            dvs    <= {1'b1, fb};
                            q      <= 10'd0;
                            cnt    <= 4'd0;
                            e_diff <= $signed({2'b00, ea}) - $signed({2'b00, eb});
                            state  <= DIV;
                        end
                    end
                end
                DIV: begin
                    q   <= {q[8:0], ~trial[10]};
                    rem <= rem_keep << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    out       <= norm_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bfp16_div.sv
// tb_bfp16_div: directed bench for bfp16_div with a behavioural divide model
// and a per-cycle result scoreboard.
module tb_bfp16_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sb[$];

    bfp16_div dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Quotient from exact integer division of the scaled mantissas.
    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        logic s;
        int ex, ey, fx, fy, num, den, qq, frac, e;
        bit nz, xn, yn, xi, yi, xz, yz;
        logic [7:0] eo;
        logic [6:0] fo;
        s  = x[15] ^ y[15];
        ex = int'(x[14:7]);
        ey = int'(y[14:7]);
        fx = int'(x[6:0]);
        fy = int'(y[6:0]);
        xn = (ex == 255) && (fx != 0);
        yn = (ey == 255) && (fy != 0);
        xi = (ex == 255) && (fx == 0);
        yi = (ey == 255) && (fy == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xn || yn) return 16'h7FC0;
        if (xi && yi) return 16'h7FC0;
        if (xz && yz) return 16'h7FC0;
        if (xi || yz) return {s, 8'hFF, 7'h00};
        if (xz || yi) return {s, 15'h0000};
        num = (128 + fx) * 512;
        den = 128 + fy;
        qq  = num / den;
        nz  = (num % den) != 0;
        if (qq >= 512) begin
            frac = (qq >> 2) & 127;
            e    = ex - ey + 127;
        end else begin
            frac = (qq >> 1) & 127;
            e    = ex - ey + 126;
        end
`ifdef BFP16_DIV_RNE_EN
        begin
            bit g, st;
            if (qq >= 512) begin
                g  = ((qq >> 1) & 1) != 0;
                st = ((qq & 1) != 0) || nz;
            end else begin
                g  = (qq & 1) != 0;
                st = nz;
            end
            if (g && (st || ((frac & 1) != 0))) frac++;
            if (frac == 128) begin
                frac = 0;
                e++;
            end
        end
`else
        if (nz) frac = frac;
`endif
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0) return {s, 15'h0000};
        eo = e[7:0];
        fo = frac[6:0];
        return {s, eo, fo};
    endfunction

    // Scoreboard: record accepted operations, check every valid result cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            sb.delete();
        end else begin
            check("vld_rdy_excl", {31'd0, out_valid & in_ready}, 32'd0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: out_valid with no accepted operation, out=%h", out);
                end else begin
                    check("model_out", {16'd0, out}, {16'd0, sb[0]});
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b));
        end
    end

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_wait_ready: in_ready=%b required 1", name, in_ready);
        end
    endtask

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] expv, input int lat, input string name);
        int cyc;
        bit bad;
        wait_ready(name);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        cyc      = 0;
        bad      = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (!busy || in_ready) bad = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_lat"}, cyc, lat);
        check({name, "_busy"}, {31'd0, bad}, 32'd0);
        check({name, "_out"}, {16'd0, out}, {16'd0, expv});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_ovld_clr"}, {31'd0, out_valid}, 32'd0);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] third;
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out", {16'd0, out}, 32'h0000);
        rst = 1'b0;

`ifdef BFP16_DIV_RNE_EN
        third = 16'h3EAB;
`else
        third = 16'h3EAA;
`endif
        // Hand-computed values pinning the model
        check("model_1p5", {16'd0, model(16'h3FC0, 16'h3F80)}, 32'h3FC0);
        check("model_third", {16'd0, model(16'h3F80, 16'h4040)}, {16'd0, third});
        check("model_neg6", {16'd0, model(16'hC0C0, 16'h4000)}, 32'hC040);
        check("model_ovf", {16'd0, model(16'h7F00, 16'h3E80)}, 32'h7F80);
        check("model_0div0", {16'd0, model(16'h0000, 16'h0000)}, 32'h7FC0);

        // Normal divisions
        run_op(16'h3FC0, 16'h3F80, 16'h3FC0, 11, "1p5_div_1");
        run_op(16'h3F80, 16'h4040, third,    11, "1_div_3");
        run_op(16'hC0C0, 16'h4000, 16'hC040, 11, "neg6_div_2");
        run_op(16'h7F00, 16'h3E80, 16'h7F80, 11, "overflow");
        run_op(16'h4000, 16'h4080, 16'h3F00, 11, "2_div_4");
        run_op(16'h0080, 16'h7F00, 16'h0000, 11, "underflow");

        // Special cases
        run_op(16'h3F80, 16'h0000, 16'h7F80, 0, "x_div_0");
        run_op(16'h0000, 16'h0000, 16'h7FC0, 0, "0_div_0");
        run_op(16'h0000, 16'hBF80, 16'h8000, 0, "0_div_neg");
        run_op(16'h7F81, 16'h3F80, 16'h7FC0, 0, "nan_in");
        run_op(16'h7F80, 16'h7F80, 16'h7FC0, 0, "inf_div_inf");
        run_op(16'hFF80, 16'h3F80, 16'hFF80, 0, "neginf_div_x");
        run_op(16'h3F80, 16'hFF80, 16'h8000, 0, "x_div_neginf");
        run_op(16'h0001, 16'h3F80, 16'h0000, 0, "subnormal_a");

        // Backpressure: result held while out_ready is low
        wait_ready("bp");
        a        = 16'h3FC0;
        b        = 16'h3F80;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("bp_lat", k, 11);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a        = 16'h4000;
            b        = 16'h4080;
            @(posedge clk);
            #1;
            check("bp_out_stable", {16'd0, out}, 32'h3FC0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_vld", {31'd0, out_valid}, 32'd0);
        check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        run_op(16'h4000, 16'h4080, 16'h3F00, 11, "b2b");

        // Reset in the middle of a division (cnt = 4)
        wait_ready("rst_mid");
        a        = 16'h3F80;
        b        = 16'h4040;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_out", {16'd0, out}, 32'h0000);
        run_op(16'hC0C0, 16'h4000, 16'hC040, 11, "after_rst");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
